// File: rtl/n64_read_response.sv
// ============================================================================
// Module   : n64_read_response
// Purpose  : Decodes an N64 controller reply (LSB-first bits + stop bit) from
//            the raw data line into a parallel word with a valid strobe.
//            Optional watchdog: define N64_READ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module n64_read_response #(
  parameter int SAMPLE   = 200,
  parameter int NUM_BITS = 32,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                data_in,
  output logic                reading_data,
  output logic [NUM_BITS-1:0] data_out,
  output logic                data_valid,
  output logic                frame_error
);

  localparam int TW = $clog2(((SAMPLE > TIMEOUT) ? SAMPLE : TIMEOUT) + 1);
  localparam int CW = $clog2(NUM_BITS + 1);

  localparam logic [TW-1:0] c_SAMPLE_LAST  = TW'(SAMPLE - 1);
  localparam logic [TW-1:0] c_TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] c_TIMER_MAX    = '1;
  localparam logic [CW-1:0] c_NUM_BITS     = CW'(NUM_BITS);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FALL  = 3'd1,
    ST_TIME_BIT   = 3'd2,
    ST_WAIT_HIGH  = 3'd3,
    ST_STOP_FALL  = 3'd4,
    ST_STOP_CHECK = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_s_prev;
  logic [TW-1:0]       r_timer;
  logic [CW-1:0]       r_bit_cnt;
  logic [NUM_BITS-1:0] r_shift;

  logic w_fall;
  logic w_take_sample;
  logic w_frame_ok;
  logic w_frame_err;

  assign w_fall       = r_s_prev & ~r_sync2;
  assign reading_data = (r_state != ST_IDLE);

  always_comb begin
    w_next_state  = r_state;
    w_take_sample = 1'b0;
    w_frame_ok    = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) w_next_state = ST_WAIT_FALL;
      end
      ST_WAIT_FALL: begin
        if (w_fall) begin
          w_next_state = ST_TIME_BIT;
        end
`ifdef N64_READ_TIMEOUT_EN
        else if (r_timer == c_TIMEOUT_LAST) begin
          w_frame_err  = 1'b1;
          w_next_state = ST_IDLE;
        end
`endif
      end
      ST_TIME_BIT: begin
        if (r_timer == c_SAMPLE_LAST) begin
          w_take_sample = 1'b1;
          w_next_state  = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (r_sync2) begin
          w_next_state = (r_bit_cnt < c_NUM_BITS) ? ST_WAIT_FALL : ST_STOP_FALL;
        end
`ifdef N64_READ_TIMEOUT_EN
        else if (r_timer == c_TIMEOUT_LAST) begin
          w_frame_err  = 1'b1;
          w_next_state = ST_IDLE;
        end
`endif
      end
      ST_STOP_FALL: begin
        if (w_fall) begin
          w_next_state = ST_STOP_CHECK;
        end
`ifdef N64_READ_TIMEOUT_EN
        else if (r_timer == c_TIMEOUT_LAST) begin
          w_frame_err  = 1'b1;
          w_next_state = ST_IDLE;
        end
`endif
      end
      ST_STOP_CHECK: begin
        if (r_timer == c_SAMPLE_LAST) begin
          w_frame_ok   = r_sync2;
          w_frame_err  = ~r_sync2;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_s_prev    <= 1'b1;
      r_timer     <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      r_sync1     <= data_in;
      r_sync2     <= r_sync1;
      r_s_prev    <= r_sync2;
      r_state     <= w_next_state;
      data_valid  <= w_frame_ok;
      frame_error <= w_frame_err;

      // Cleared on every state change and saturating, so it can never wrap.
      if (w_next_state != r_state) begin
        r_timer <= '0;
      end else if (r_timer != c_TIMER_MAX) begin
        r_timer <= r_timer + TW'(1);
      end

      if (r_state == ST_IDLE && en) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end

      // Right shift in at the MSB: after NUM_BITS samples the first bit sits in bit 0.
      if (w_take_sample) begin
        r_shift   <= {r_sync2, r_shift[NUM_BITS-1:1]};
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end

      if (w_frame_ok) data_out <= r_shift;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_n64_read_response.sv
// ============================================================================
// Module   : tb_n64_read_response
// Purpose  : Directed self-checking bench for n64_read_response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n64_read_response;

  localparam int SAMPLE   = 200;
  localparam int NUM_BITS = 32;
  localparam int TIMEOUT  = 1000;

  logic                clk;
  logic                rst;
  logic                en;
  logic                data_in;
  logic                reading_data;
  logic [NUM_BITS-1:0] data_out;
  logic                data_valid;
  logic                frame_error;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;

  n64_read_response #(
    .SAMPLE  (SAMPLE),
    .NUM_BITS(NUM_BITS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .data_in     (data_in),
    .reading_data(reading_data),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse-cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (data_valid) n_valid++;
    if (frame_error) n_err++;
    if (data_valid && frame_error) n_both++;
  end

  task automatic send_cell(input logic b, input int lo, input int hi, input bit glitch);
    data_in = 1'b0;
    repeat (lo) @(negedge clk);
    data_in = b;
    if (glitch) begin
      repeat (50) @(negedge clk);
      data_in = 1'b0;
      repeat (3) @(negedge clk);
      data_in = b;
      repeat (147) @(negedge clk);
    end else begin
      repeat (200) @(negedge clk);
    end
    data_in = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic arm();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [NUM_BITS-1:0] w, input logic stop,
                            input bit jitter, input int glitch_bit);
    int lo;
    int hi;
    for (int i = 0; i < NUM_BITS; i++) begin
      lo = jitter ? 80 + (i % 3) * 20 : 100;
      hi = jitter ? 120 - (i % 3) * 20 : 100;
      send_cell(w[i], lo, hi, (i == glitch_bit));
    end
    send_cell(stop, 100, 100, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; data_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (reading_data !== 1'b0) begin errors++; $display("FAIL reset_reading_data got %b want 0", reading_data); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got %h want 00000000", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
  endtask

  task automatic test_basic();
    int v0 = n_valid;
    int e0 = n_err;
    arm();
    send_frame(32'h0000_8001, 1'b1, 1'b0, -1);
    checks++; if (data_out !== 32'h0000_8001) begin errors++; $display("FAIL basic_data got %h want 00008001", data_out); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL basic_valid_cycles got %0d want 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL basic_error_cycles got %0d want 0", n_err - e0); end
    checks++; if (reading_data !== 1'b0) begin errors++; $display("FAIL basic_reading_done got %b want 0", reading_data); end
  endtask

  task automatic test_jitter();
    int v0 = n_valid;
    arm();
    send_frame(32'hAAAA_5555, 1'b1, 1'b1, -1);
    checks++; if (data_out !== 32'hAAAA_5555) begin errors++; $display("FAIL jitter_data got %h want aaaa5555", data_out); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL jitter_valid_cycles got %0d want 1", n_valid - v0); end
  endtask

  task automatic test_stop_error();
    int v0 = n_valid;
    int e0 = n_err;
    arm();
    send_frame(32'h1357_9BDF, 1'b0, 1'b0, -1);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL stop_error_cycles got %0d want 1", n_err - e0); end
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL stop_valid_cycles got %0d want 0", n_valid - v0); end
    checks++; if (data_out !== 32'hAAAA_5555) begin errors++; $display("FAIL stop_data_hold got %h want aaaa5555", data_out); end
    checks++; if (reading_data !== 1'b0) begin errors++; $display("FAIL stop_reading_done got %b want 0", reading_data); end
  endtask

  task automatic test_glitch();
    int v0 = n_valid;
    arm();
    send_frame(32'hFFFF_FFFF, 1'b1, 1'b0, 5);
    checks++; if (data_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL glitch_data got %h want ffffffff", data_out); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL glitch_valid_cycles got %0d want 1", n_valid - v0); end
  endtask

  task automatic test_reset_mid_frame();
    int v0 = n_valid;
    int e0 = n_err;
    arm();
    for (int i = 0; i < 10; i++) send_cell(1'b1, 100, 100, 1'b0);
    data_in = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    data_in = 1'b1;
    @(negedge clk);
    checks++; if (reading_data !== 1'b0) begin errors++; $display("FAIL midrst_reading got %b want 0", reading_data); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL midrst_data_out got %h want 00000000", data_out); end
    repeat (400) @(negedge clk);
    checks++; if ((n_valid - v0) + (n_err - e0) !== 0) begin errors++; $display("FAIL midrst_no_pulse got %0d want 0", (n_valid - v0) + (n_err - e0)); end
    arm();
    send_frame(32'h1234_5678, 1'b1, 1'b0, -1);
    checks++; if (data_out !== 32'h1234_5678) begin errors++; $display("FAIL midrst_data got %h want 12345678", data_out); end
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL midrst_valid_cycles got %0d want 1", n_valid - v0); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit seen = 0;
    data_in = 1'b1;
    en = 1'b1;
`ifdef N64_READ_TIMEOUT_EN
    @(negedge clk);
    en = 1'b0;
    cnt = 1;
    while (!seen && cnt < 3 * TIMEOUT) begin
      if (frame_error) seen = 1;
      else begin
        @(negedge clk);
        cnt++;
      end
    end
    checks++; if (cnt !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency got %0d want %0d", cnt, TIMEOUT + 1); end
    checks++; if (reading_data !== 1'b0) begin errors++; $display("FAIL timeout_idle got %b want 0", reading_data); end
`else
    @(negedge clk);
    en = 1'b0;
    repeat (5000) begin
      @(negedge clk);
      if (!reading_data) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL no_timeout_low_cycles got %0d want 0", cnt); end
    checks++; if (n_err !== 1) begin errors++; $display("FAIL no_timeout_error_total got %0d want 1", n_err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jitter();
    test_stop_error();
    test_glitch();
    test_reset_mid_frame();
    test_timeout();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_and_error_together got %0d want 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
